lsu_mem_initiator: RTL and testbench

Load/store initiator that sits between the pipeline's memory stage and the word-addressed data memory. It accepts one RISC-V load or store request at a time through a valid/ready handshake and drives the memory's `we`/`addr`/`wr_data` port. Sub-word stores become a two-step read-modify-write. It returns byte/halfword/word load data, sign- or zero-extended, through a valid/ready response channel.

---
 rtl/lsu_mem_initiator.sv | 177 +++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one RISC-V load/store at a time onto a word-addressed memory port,
// with read-modify-write for sub-word stores and extended load data on a valid/ready response.
module lsu_mem_initiator #(
   parameter int word_size     = 32,
   parameter int address_width = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_store,
   input  logic [2:0]               req_funct3,
   input  logic [address_width-1:0] req_addr,
   input  logic [word_size-1:0]     req_wdata,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [word_size-1:0]     resp_rdata,
   output logic                     resp_fault,
   output logic                     mem_we,
   output logic [address_width-1:0] mem_addr,
   output logic [word_size-1:0]     mem_wr_data,
   input  logic [word_size-1:0]     mem_rd_data
);

   typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

   state_t                     r_state;
   logic                       r_pending;
   logic                       r_store;
   logic [2:0]                 r_funct3;
   logic [address_width-1:0]   r_addr;
   logic [word_size-1:0]       r_wdata;
   logic                       r_req_ready;
   logic                       r_resp_valid;
   logic [word_size-1:0]       r_resp_rdata;
   logic                       r_resp_fault;
   logic                       r_mem_we;
   logic [address_width-1:0]   r_mem_addr;
   logic [word_size-1:0]       r_mem_wr_data;

   logic [address_width-1:0]   w_aligned;
   logic                       w_illegal;
   logic [7:0]                 w_byte;
   logic [15:0]                w_half;
   logic [word_size-1:0]       w_load_data;
   logic [word_size-1:0]       w_merge;

   assign w_aligned = {r_addr[address_width-1:2], 2'b00};
   assign w_byte    = mem_rd_data[{r_addr[1:0], 3'b000} +: 8];
   assign w_half    = mem_rd_data[{r_addr[1], 4'b0000} +: 16];

   always_comb begin
      w_illegal = 1'b1;
      case (r_funct3)
         3'b000:          w_illegal = 1'b0;
         3'b001:          w_illegal = r_addr[0];
         3'b010:          w_illegal = (r_addr[1:0] != 2'b00);
         3'b100:          w_illegal = r_store;
         3'b101:          w_illegal = r_store | r_addr[0];
         default:         w_illegal = 1'b1;
      endcase
   end

   always_comb begin
      w_load_data = mem_rd_data;
      case (r_funct3)
         3'b000:  w_load_data = {{(word_size-8){w_byte[7]}}, w_byte};
         3'b100:  w_load_data = {{(word_size-8){1'b0}}, w_byte};
         3'b001:  w_load_data = {{(word_size-16){w_half[15]}}, w_half};
         3'b101:  w_load_data = {{(word_size-16){1'b0}}, w_half};
         default: w_load_data = mem_rd_data;
      endcase
   end

   // Only SB/SH reach the merge, so funct3 000 selects byte, anything else halfword.
   always_comb begin
      w_merge = mem_rd_data;
      if (r_funct3 == 3'b000)
         w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      else
         w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_pending     <= 1'b0;
         r_store       <= 1'b0;
         r_funct3      <= 3'b000;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_req_ready   <= 1'b0;
         r_resp_valid  <= 1'b0;
         r_resp_rdata  <= '0;
         r_resp_fault  <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wr_data <= '0;
      end else begin
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wr_data <= '0;
         case (r_state)
            IDLE: begin
               // The accept edge only latches the request; the next edge decodes it.
               if (r_pending) begin
                  r_pending <= 1'b0;
                  if (w_illegal) begin
                     r_state      <= RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_fault <= 1'b1;
                     r_resp_rdata <= '0;
                  end else if (!r_store) begin
                     r_state    <= RD;
                     r_mem_addr <= w_aligned;
                  end else if (r_funct3 == 3'b010) begin
                     r_state       <= WR;
                     r_mem_we      <= 1'b1;
                     r_mem_addr    <= w_aligned;
                     r_mem_wr_data <= r_wdata;
                  end else begin
                     r_state    <= RMW_RD;
                     r_mem_addr <= w_aligned;
                  end
               end else begin
                  r_req_ready <= 1'b1;
                  if (req_valid && r_req_ready) begin
                     r_store     <= req_store;
                     r_funct3    <= req_funct3;
                     r_addr      <= req_addr;
                     r_wdata     <= req_wdata;
                     r_pending   <= 1'b1;
                     r_req_ready <= 1'b0;
                  end
               end
            end
            RD: begin
               r_state      <= RESP;
               r_resp_valid <= 1'b1;
               r_resp_fault <= 1'b0;
               r_resp_rdata <= w_load_data;
            end
            RMW_RD: begin
               r_state       <= WR;
               r_mem_we      <= 1'b1;
               r_mem_addr    <= w_aligned;
               r_mem_wr_data <= w_merge;
            end
            WR: begin
               r_state      <= RESP;
               r_resp_valid <= 1'b1;
               r_resp_fault <= 1'b0;
               r_resp_rdata <= '0;
            end
            RESP: begin
               if (resp_ready) begin
                  r_state      <= IDLE;
                  r_resp_valid <= 1'b0;
                  r_resp_fault <= 1'b0;
                  r_resp_rdata <= '0;
                  r_req_ready  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready   = r_req_ready;
   assign resp_valid  = r_resp_valid;
   assign resp_rdata  = r_resp_rdata;
   assign resp_fault  = r_resp_fault;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_wr_data = r_mem_wr_data;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Randomized + directed bench for lsu_mem_initiator against a byte-mask memory model.
module tb_lsu_mem_initiator;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_fault;
   logic [31:0] resp_rdata;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wr_data, mem_rd_data;

   logic [31:0] mem     [0:63];
   logic [31:0] ref_mem [0:63];
   logic        init_we;
   logic [5:0]  init_idx;
   logic [31:0] init_data;
   int          wr_count = 0;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   lsu_mem_initiator #(.word_size(32), .address_width(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_fault(resp_fault),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
      .mem_rd_data(mem_rd_data)
   );

   assign mem_rd_data = mem[mem_addr[7:2]];

   always @(posedge clk) begin
      if (mem_we)
         mem[mem_addr[7:2]] <= mem_wr_data;
      else if (init_we)
         mem[init_idx] <= init_data;
   end

   always @(posedge clk)
      if (mem_we) wr_count <= wr_count + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Reference: a sized byte-lane view of the word, independent of any FSM timing.
   function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] word,
                                 output logic fault, output logic [31:0] rdata,
                                 output logic [31:0] new_word, output int lat);
      int          size, o;
      logic [63:0] lane, mask, v;
      o     = int'(addr % 4);
      size  = 1 << f3[1:0];
      fault = (f3[1:0] == 2'b11) || (f3[2] && (st || f3[1:0] == 2'b10)) || ((addr % size) != 0);
      lane  = (64'd1 << (8 * size)) - 64'd1;
      mask  = lane << (8 * o);
      rdata = '0;
      new_word = word;
      lat   = 1;
      if (!fault) begin
         if (st) begin
            v        = (64'(word) & ~mask) | ((64'(wd) << (8 * o)) & mask);
            new_word = v[31:0];
            lat      = (size == 4) ? 2 : 3;
         end else begin
            v = (64'(word) >> (8 * o)) & lane;
            if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~lane;
            rdata = v[31:0];
            lat   = 2;
         end
      end
   endfunction

   task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int hold,
                         output logic [31:0] got_rdata, output logic got_fault);
      logic        e_fault, act_mem, we_c;
      logic [31:0] e_rdata, e_word, aligned;
      int          lat, wc0;
      logic        ok;
      model(st, f3, addr, wd, ref_mem[addr[7:2]], e_fault, e_rdata, e_word, lat);
      aligned   = addr & 32'hFFFF_FFFC;
      got_rdata = '0;
      got_fault = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      resp_ready = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (req_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("accept", 32'(ok), 32'd1);
      if (!ok) begin req_valid = 1'b0; return; end
      wc0 = wr_count;
      @(posedge clk);
      for (int k = 0; k <= lat + hold; k++) begin
         @(negedge clk);
         // Noise on the request side must not disturb an operation in flight.
         req_valid  = 1'($urandom_range(0, 1));
         req_store  = 1'($urandom_range(0, 1));
         req_funct3 = 3'($urandom_range(0, 7));
         req_addr   = $urandom;
         req_wdata  = $urandom;
         act_mem = !e_fault && k >= 1 && k <= lat - 1;
         we_c    = st && act_mem && (k == lat - 1);
         chk("req_ready_busy", 32'(req_ready), 32'd0);
         chk("mem_we", 32'(mem_we), 32'(we_c));
         chk("mem_addr", mem_addr, act_mem ? aligned : 32'd0);
         chk("mem_wr_data", mem_wr_data, we_c ? e_word : 32'd0);
         chk("resp_valid", 32'(resp_valid), 32'(k >= lat));
         if (k >= lat) begin
            chk("resp_rdata", resp_rdata, e_rdata);
            chk("resp_fault", 32'(resp_fault), 32'(e_fault));
            got_rdata = resp_rdata;
            got_fault = resp_fault;
         end
         resp_ready = (k == lat + hold);
      end
      @(negedge clk);
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      chk("req_ready_after", 32'(req_ready), 32'd1);
      chk("resp_valid_after", 32'(resp_valid), 32'd0);
      chk("write_pulses", 32'(wr_count - wc0), (st && !e_fault) ? 32'd1 : 32'd0);
      ref_mem[addr[7:2]] = e_word;
      chk("mem_word", mem[addr[7:2]], e_word);
      $display("txn st=%0d f3=%0d addr=%h wd=%h -> rdata=%h fault=%0d word=%h",
               st, f3, addr, wd, got_rdata, got_fault, mem[addr[7:2]]);
   endtask

   initial begin
      logic [31:0] r, w0, sb_wd;
      logic        f;
      reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
      init_we = 1'b0; init_idx = '0; init_data = '0;

      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         init_we   = 1'b1;
         init_idx  = 6'(i);
         init_data = (i == 4) ? 32'h8899AABB : $urandom;
         ref_mem[i] = init_data;
      end
      @(negedge clk);
      init_we = 1'b0;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp", {resp_valid, resp_fault, 30'd0}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_mem", {31'd0, mem_we} | mem_addr | mem_wr_data, 32'd0);
      reset = 1'b0;
      chk("rel_req_ready_now", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("rel_req_ready_next", 32'(req_ready), 32'd1);

      do_txn(1'b0, 3'b010, 32'h10, 32'h0, 0, r, f); chk("lit_lw", r, 32'h8899AABB);
      do_txn(1'b0, 3'b000, 32'h11, 32'h0, 0, r, f); chk("lit_lb", r, 32'hFFFFFFAA);
      do_txn(1'b0, 3'b100, 32'h11, 32'h0, 1, r, f); chk("lit_lbu", r, 32'h000000AA);
      do_txn(1'b0, 3'b001, 32'h12, 32'h0, 0, r, f); chk("lit_lh", r, 32'hFFFF8899);
      do_txn(1'b0, 3'b101, 32'h12, 32'h0, 2, r, f); chk("lit_lhu", r, 32'h00008899);
      do_txn(1'b1, 3'b000, 32'h13, 32'h12345677, 0, r, f); chk("lit_sb", mem[4], 32'h7799AABB);
      do_txn(1'b1, 3'b001, 32'h10, 32'h0000CAFE, 0, r, f); chk("lit_sh", mem[4], 32'h7799CAFE);
      do_txn(1'b0, 3'b010, 32'h12, 32'h0, 0, r, f); chk("lit_flt_lw", {31'd0, f}, 32'd1);
      do_txn(1'b1, 3'b001, 32'h11, 32'h5555, 0, r, f); chk("lit_flt_sh", {31'd0, f}, 32'd1);
      do_txn(1'b0, 3'b011, 32'h10, 32'h0, 0, r, f); chk("lit_flt_f3", {31'd0, f}, 32'd1);
      chk("lit_flt_mem", mem[4], 32'h7799CAFE);
      do_txn(1'b0, 3'b010, 32'h10, 32'h0, 5, r, f); chk("lit_bp_lw", r, 32'h7799CAFE);

      // Reset landing in the read half of an SB read-modify-write.
      w0 = mem[4];
      sb_wd = $urandom;
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h12; req_wdata = sb_wd;
      chk("rmw_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("rmw_rd_addr", mem_addr, 32'h10);
      chk("rmw_rd_we", 32'(mem_we), 32'd0);
      reset = 1'b1;
      #1;
      chk("rmw_rst_outs", {31'd0, mem_we} | mem_addr | mem_wr_data | resp_rdata, 32'd0);
      chk("rmw_rst_flags", {29'd0, req_ready, resp_valid, resp_fault}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      chk("rmw_rel_ready_now", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("rmw_rel_ready_next", 32'(req_ready), 32'd1);
      chk("rmw_mem_unchanged", mem[4], w0);
      $display("reset mid-RMW: word=%h", mem[4]);

      for (int n = 0; n < 300; n++) begin
         do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)),
                $urandom, int'($urandom_range(0, 3)), r, f);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
